time_display_mux: RTL
=====================

// Module: time_display_mux
// PURPOSE
//  Downstream consumer of the countdown timer's countMin/countSeg outputs.
//  Converts both 6-bit binary values to 2-digit BCD with a sequential double-dabble engine.
//  Drives a 4-digit common-anode 7-segment display by time-multiplexing, format MM.SS.
//  Snapshots its inputs once per scan frame, so the four digits always show one coherent time.
// PARAMETERS
//  SIZE        6      width of the minute/second inputs; must match the timer's SIZE
//  REFRESH_DIV 12500  clk cycles each digit is lit (50 MHz -> 4 kHz digit rate, 1 kHz frame); must be >= 16
//  BLINK_DIV   25e6   clk cycles per blink half-period (used only with TIME_DISPLAY_BLINK_EN)
// PORTS
//  clk     in   1       system clock (same clk as the timer)
//  rst     in   1       synchronous, active-high reset
//  min_in  in   SIZE    minutes to display (binary, from countMin)
//  seg_in  in   SIZE    seconds to display (binary, from countSeg)
//  an      out  4       digit anodes, active-low; an[3]=min tens .. an[0]=sec units
//  seg     out  7       segments {g,f,e,d,c,b,a}, active-low
//  dp      out  1       decimal point, active-low; lit only on digit 2 (the MM.SS separator)
// BEHAVIOUR
//  Reset: an=4'b1111, seg=7'h7F, dp=1 (display dark); digit index=3; dwell counter=0; BCD regs=0.
//  - Display stays dark after reset until the first conversion completes.
//  Dwell counter counts 0..REFRESH_DIV-1. On wrap the digit index decrements 3->2->1->0->3.
//  Frame start is the index wrap 0->3 (also the first cycle after reset):
//  - latch {min_in, seg_in} into a snapshot;
//  - pulse start to the converter.
//  Converter FSM IDLE->SHIFT->DONE:
//  - SHIFT runs SIZE iterations: add 3 to any BCD nibble >= 5, then shift left.
//  - DONE holds the result valid; it returns to IDLE on the next start.
//  - Minutes and seconds are converted in parallel (two instances); latency SIZE+2 cycles.
//  - BCD display regs update only on DONE; earlier BCD values stay on the display until then.
//  Values 60..63 are shown faithfully (e.g. 63 -> "63"); no saturation.
//  Digit index selects the BCD nibble; seg = active-low pattern of that nibble (0-9 only).
//  an/seg/dp are registered: 1 cycle after the index changes.
//  Blanking: for the first 2 cycles of each dwell, an=4'b1111 to prevent ghosting.
//  Input change to display update: at most one frame (4*REFRESH_DIV) + SIZE+3 cycles.
//  min_in/seg_in changing mid-frame have no effect until the next frame start.
//  rst asserted mid-conversion: FSM returns to IDLE, outputs return to reset values next cycle.
// CONFIGURATION
//  TIME_DISPLAY_BLINK_EN defined:
//  - when the snapshot is 00:00, an is forced to 4'b1111 during alternate BLINK_DIV periods;
//  - the blink counter is reset whenever the snapshot is nonzero.
//  Not defined: 00:00 is shown steadily; no blink counter is synthesized.
// STRUCTURE
//  Package time_display_pkg:
//  - SEG7_LUT[0:9] active-low segment constants; SEG7_BLANK=7'h7F;
//  - digit index typedef (2 bits); conversion FSM state encoding.
//  Sub-module bin2bcd_seq (start, bin[SIZE-1:0] -> tens[3:0], units[3:0], done), instantiated twice.
//  Top level holds the scan counter, snapshot regs, digit mux and blink logic.
// TESTING
//  Use REFRESH_DIV=16 in simulation.
//  1. rst high 3 cycles -> an=1111, seg=7F, dp=1; after frame 1 plus 8 cycles, an[3] low with seg=SEG7_LUT[d].
//  2. min_in=12, seg_in=34 -> digits decode 1,2,3,4 in scan order 3..0; dp=0 only while an=1011.
//  3. seg_in changes 34->33 mid-frame -> current frame still shows 34; next frame shows 33.
//  4. min_in=63, seg_in=59 -> digits 6,3,5,9; check the conversion takes SIZE+2 cycles after start.
//  5. min_in=0, seg_in=0:
//     - with TIME_DISPLAY_BLINK_EN and BLINK_DIV=64 -> an=1111 during alternate 64-cycle windows;
//     - without the macro -> 0,0,0,0 shown steadily.
//  6. rst pulsed mid-conversion -> outputs dark next cycle; correct digits resume one frame after release.

Source files
------------

// File: rtl/time_display_pkg.sv
// Shared constants and types for the MM.SS display multiplexer: segment
// patterns, digit index type and the conversion FSM encoding.
package time_display_pkg;

  // Active-low {g,f,e,d,c,b,a}; a 0 bit lights that segment.
  localparam logic [6:0] SEG7_BLANK = 7'h7F;
  localparam logic [6:0] SEG7_LUT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  typedef logic [1:0] digit_idx_t;

  localparam digit_idx_t DIGIT_MIN_TENS  = 2'd3;
  localparam digit_idx_t DIGIT_MIN_UNITS = 2'd2;
  localparam digit_idx_t DIGIT_SEC_TENS  = 2'd1;
  localparam digit_idx_t DIGIT_SEC_UNITS = 2'd0;

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_SHIFT = 2'd1,
    CONV_DONE  = 2'd2
  } conv_state_t;

  function automatic logic [6:0] seg7_encode(input logic [3:0] nibble);
    logic [6:0] pattern;
    pattern = SEG7_BLANK;
    if (nibble <= 4'd9) begin
      pattern = SEG7_LUT[nibble];
    end
    return pattern;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: SIZE-bit binary to two BCD digits.
// done rises SIZE+2 cycles after start and holds until the next start.
module bin2bcd_seq
  import time_display_pkg::*;
#(
  parameter int SIZE = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] bin,
  output logic [3:0]      tens,
  output logic [3:0]      units,
  output logic            done
);

  localparam int IW = $clog2(SIZE + 1);

  conv_state_t     state_q, state_d;
  logic [SIZE-1:0] bin_q, bin_d;
  logic [7:0]      bcd_q, bcd_d;
  logic [IW-1:0]   iter_q, iter_d;
  logic [7:0]      bcd_adj;

  always_comb begin
    bcd_adj[3:0] = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    bcd_adj[7:4] = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
  end

  // A start seen in DONE behaves as DONE->IDLE->SHIFT in one step, so every
  // frame's conversion has the same latency. The SHIFT pass with
  // iter_q == SIZE is a settle cycle that performs no shift.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    case (state_q)
      CONV_IDLE, CONV_DONE: begin
        if (start) begin
          bin_d   = bin;
          bcd_d   = '0;
          iter_d  = '0;
          state_d = CONV_SHIFT;
        end
      end
      CONV_SHIFT: begin
        if (iter_q == IW'(SIZE)) begin
          state_d = CONV_DONE;
        end else begin
          bcd_d  = {bcd_adj[6:0], bin_q[SIZE-1]};
          bin_d  = bin_q << 1;
          iter_d = iter_q + 1'b1;
        end
      end
      default: state_d = CONV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CONV_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      iter_q  <= iter_d;
    end
  end

  assign tens  = bcd_q[7:4];
  assign units = bcd_q[3:0];
  assign done  = (state_q == CONV_DONE);

endmodule

// File: rtl/time_display_mux.sv
// Four-digit MM.SS multiplexed 7-segment driver. Optional 00:00 blinking is
// enabled by defining TIME_DISPLAY_BLINK_EN.
module time_display_mux
  import time_display_pkg::*;
#(
  parameter int SIZE        = 6,
  parameter int REFRESH_DIV = 12500
`ifdef TIME_DISPLAY_BLINK_EN
  ,
  parameter int BLINK_DIV   = 25000000
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] min_in,
  input  logic [SIZE-1:0] seg_in,
  output logic [3:0]      an,
  output logic [6:0]      seg,
  output logic            dp
);

  localparam int CW = $clog2(REFRESH_DIV);

  logic [CW-1:0]     cnt_q, cnt_d;
  digit_idx_t        idx_q, idx_d;
  logic [2*SIZE-1:0] snap_q, snap_d;
  logic [15:0]       bcd_q, bcd_d;
  logic              valid_q, valid_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic              dwell_wrap;
  logic              frame_start;
  logic [3:0]        min_tens, min_units, sec_tens, sec_units;
  logic              min_done, sec_done, conv_done;
  logic [3:0]        nibble;
  logic              lit;
  logic              blink_blank;

  assign dwell_wrap  = (cnt_q == CW'(REFRESH_DIV - 1));
  // Index 3 with a fresh dwell is both the post-reset cycle and every 0->3 wrap.
  assign frame_start = (idx_q == DIGIT_MIN_TENS) && (cnt_q == '0);

  always_comb begin
    cnt_d  = dwell_wrap ? '0 : cnt_q + 1'b1;
    idx_d  = dwell_wrap ? idx_q - 1'b1 : idx_q;
    snap_d = frame_start ? {min_in, seg_in} : snap_q;
  end

  bin2bcd_seq #(.SIZE(SIZE)) u_min_conv (
    .clk   (clk),
    .rst   (rst),
    .start (frame_start),
    .bin   (snap_d[2*SIZE-1:SIZE]),
    .tens  (min_tens),
    .units (min_units),
    .done  (min_done)
  );

  bin2bcd_seq #(.SIZE(SIZE)) u_sec_conv (
    .clk   (clk),
    .rst   (rst),
    .start (frame_start),
    .bin   (snap_d[SIZE-1:0]),
    .tens  (sec_tens),
    .units (sec_units),
    .done  (sec_done)
  );

  assign conv_done = min_done && sec_done;

  always_comb begin
    bcd_d   = conv_done ? {min_tens, min_units, sec_tens, sec_units} : bcd_q;
    valid_d = valid_q || conv_done;
  end

`ifdef TIME_DISPLAY_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic          snap_zero;

  assign snap_zero = (snap_q == '0);

  // Phase 0 shows the digits, phase 1 darkens them; a nonzero time restarts it.
  always_comb begin
    blink_cnt_d   = '0;
    blink_phase_d = 1'b0;
    if (snap_zero) begin
      if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign blink_blank = snap_zero && blink_phase_q;
`else
  assign blink_blank = 1'b0;
`endif

  always_comb begin
    case (idx_q)
      DIGIT_MIN_TENS:  nibble = bcd_q[15:12];
      DIGIT_MIN_UNITS: nibble = bcd_q[11:8];
      DIGIT_SEC_TENS:  nibble = bcd_q[7:4];
      DIGIT_SEC_UNITS: nibble = bcd_q[3:0];
      default:         nibble = bcd_q[3:0];
    endcase
  end

  // The first two cycles of every dwell stay dark so the previous digit's
  // segments never bleed onto the newly selected anode.
  always_comb begin
    lit  = valid_q && (cnt_q >= CW'(2)) && !blink_blank;
    an_d = 4'b1111;
    seg_d = SEG7_BLANK;
    dp_d = 1'b1;
    if (lit) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = seg7_encode(nibble);
      dp_d  = (idx_q != DIGIT_MIN_UNITS);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= DIGIT_MIN_TENS;
      snap_q  <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
      an_q    <= 4'b1111;
      seg_q   <= SEG7_BLANK;
      dp_q    <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
